// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM states,
// default widths and operand-signedness helpers.
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN  = 32;
  localparam int unsigned MULDIV_CNT_W = 6;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/write-back bundle between the core and muldiv_unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            we;
  logic [4:0]      wa;

  modport master (
    output start, funct3, rs1, rs2, rd_addr,
    input  busy, done, result, we, wa
  );

  modport slave (
    input  start, funct3, rs1, rs2, rd_addr,
    output busy, done, result, we, wa
  );
endinterface

// File: rtl/udiv_iter.sv
// Unsigned restoring-divide datapath: one quotient bit per step, MSB first.
module udiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            step_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);
  logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN:0]   trial, diff;

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    trial  = {rem_q, quot_q[XLEN-1]};
    // Bit XLEN of the difference is set exactly when trial < divisor.
    diff   = trial - {1'b0, dvs_q};
    if (load_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_d  = diff[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = trial[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Define MULDIV_FAST_MUL_EN to replace the
// 32-step shift-add multiplier with a single-cycle 33x33 signed multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = MULDIV_XLEN,
  parameter int unsigned CNT_W = MULDIV_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  muldiv_if.slave   mdu
);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [XLEN-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          wa_q, wa_d;

  logic                accept, a_neg_in, b_neg_in, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag_in, b_mag_in, a_mag, quot, rem, fix_result;
  logic [XLEN:0]       mul_sum;
  logic                div_load, div_step, last_iter;

  assign accept    = mdu.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign a_neg_in  = op_a_signed(mdu.funct3) & mdu.rs1[XLEN-1];
  assign b_neg_in  = op_b_signed(mdu.funct3) & mdu.rs2[XLEN-1];
  assign a_mag_in  = a_neg_in ? -mdu.rs1 : mdu.rs1;
  assign b_mag_in  = b_neg_in ? -mdu.rs2 : mdu.rs2;
  assign div_zero  = mdu.funct3[2] && (mdu.rs2 == '0);
  assign div_ovf   = (mdu.funct3 == F3_DIV || mdu.funct3 == F3_REM) &&
                     (mdu.rs1 == INT_MIN) && (mdu.rs2 == '1);
  assign a_mag     = a_neg_q ? -opa_q : opa_q;
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag} : '0);
  assign last_iter = (cnt_q == CNT_W'(XLEN-1));
  assign div_load  = accept && mdu.funct3[2];

  udiv_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .dividend_i (a_mag_in),
    .divisor_i  (b_mag_in),
    .step_i     (div_step),
    .quot_o     (quot),
    .rem_o      (rem)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  assign fast_prod = $signed({op_a_signed(f3_q) & opa_q[XLEN-1], opa_q}) *
                     $signed({op_b_signed(f3_q) & opb_q[XLEN-1], opb_q});
`endif

  always_comb begin
    logic [2*XLEN-1:0] p;
    logic              neg_p;
`ifdef MULDIV_FAST_MUL_EN
    neg_p = 1'b0;
`else
    neg_p = a_neg_q ^ b_neg_q;
`endif
    p = neg_p ? -prod_q : prod_q;
    unique case (f3_q)
      F3_MUL:                         fix_result = p[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   fix_result = p[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                fix_result = (a_neg_q ^ b_neg_q) ? -quot : quot;
      default:                        fix_result = a_neg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    prod_d   = prod_q;
    result_d = result_q;
    wa_d     = wa_q;
    div_step = 1'b0;
    unique case (state_q)
      ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        prod_d  = fast_prod[2*XLEN-1:0];
        state_d = ST_FIX;
`else
        prod_d = {mul_sum, prod_q[XLEN-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
`endif
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fix_result;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase
    // DONE accepts a new request in the same cycle, so accept overrides the above.
    if (accept) begin
      f3_d    = mdu.funct3;
      opa_d   = mdu.rs1;
      opb_d   = mdu.rs2;
      a_neg_d = a_neg_in;
      b_neg_d = b_neg_in;
      wa_d    = mdu.rd_addr;
      cnt_d   = '0;
      prod_d  = {{XLEN{1'b0}}, b_mag_in};
      if (div_zero) begin
        result_d = mdu.funct3[1] ? mdu.rs1 : '1;
        state_d  = ST_DONE;
      end else if (div_ovf) begin
        result_d = mdu.funct3[1] ? '0 : INT_MIN;
        state_d  = ST_DONE;
      end else begin
        state_d = mdu.funct3[2] ? ST_DIV : ST_MUL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      prod_q   <= '0;
      result_q <= '0;
      wa_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      wa_q     <= wa_d;
    end
  end

  assign mdu.busy   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign mdu.done   = (state_q == ST_DONE);
  assign mdu.we     = (state_q == ST_DONE) && (wa_q != '0);
  assign mdu.result = result_q;
  assign mdu.wa     = wa_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed RV32M results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.rs1     = a;
    bus.rs2     = b;
    bus.rd_addr = rd;
  endtask

  // Waits for done after the accepting edge; lat is the cycle count (1 = first cycle after accept).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_r, input int exp_lat);
    int lat;
    @(negedge clk);
    drive(f, a, b, rd);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rs1   = 32'hDEAD_BEEF;
    bus.rs2   = 32'h1234_5678;
    check({tag, ".busy"}, 32'(bus.busy), 32'(exp_lat > 1));
    wait_done(lat);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".result"}, bus.result, exp_r);
    check({tag, ".we"}, 32'(bus.we), 32'(rd != 5'd0));
    check({tag, ".wa"}, 32'(bus.wa), 32'(rd));
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".hold"}, bus.result, exp_r);
  endtask

  initial begin
    int lat;
    int dones;
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0; bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",   32'(bus.busy), 32'd0);
    check("rst.done",   32'(bus.done), 32'd0);
    check("rst.we",     32'(bus.we),   32'd0);
    check("rst.result", bus.result,    32'd0);
    check("rst.wa",     32'(bus.wa),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("mul",    F3_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    do_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, MUL_LAT);
    do_op("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, MUL_LAT);
    do_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd3,  32'hFFFF_FFFF, MUL_LAT);
    do_op("div",    F3_DIV,    32'hFFFF_FFF9, 32'd2,        5'd4,  32'hFFFF_FFFD, DIV_LAT);
    do_op("rem",    F3_REM,    32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF, DIV_LAT);
    do_op("divu",   F3_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,        DIV_LAT);
    do_op("remu",   F3_REMU,   32'd100,      32'd7,        5'd8,  32'd2,         DIV_LAT);
    do_op("divu0",  F3_DIVU,   32'd5,        32'd0,        5'd9,  32'hFFFF_FFFF, 1);
    do_op("rem0",   F3_REM,    32'd5,        32'd0,        5'd10, 32'd5,         1);
    do_op("divovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    do_op("removf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1);
    do_op("wa0",    F3_MUL,    32'd6,        32'd7,        5'd0,  32'd42,        MUL_LAT);

    // start pulsed mid-operation must be ignored
    @(negedge clk);
    drive(F3_DIVU, 32'd100, 32'd7, 5'd3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int c = 1; c < 80; c++) begin
      if (c == 10) drive(F3_MUL, 32'd2, 32'd2, 5'd9);
      if (c == 11) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        check("ign.result", bus.result, 32'd14);
        check("ign.wa", 32'(bus.wa), 32'd3);
      end
      @(posedge clk); #1;
    end
    check("ign.dones", dones, 1);

    // back-to-back: new start accepted in the DONE cycle
    @(negedge clk);
    drive(F3_DIVU, 32'd100, 32'd7, 5'd4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    check("b2b.lat1", lat, DIV_LAT);
    check("b2b.res1", bus.result, 32'd14);
    drive(F3_REMU, 32'd100, 32'd7, 5'd6);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b.busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("b2b.lat2", lat, DIV_LAT);
    check("b2b.res2", bus.result, 32'd2);
    check("b2b.wa2", 32'(bus.wa), 32'd6);
    @(posedge clk); #1;

    // reset mid-divide aborts with no write-back
    @(negedge clk);
    drive(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("rstmid.busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid.busy",   32'(bus.busy), 32'd0);
    check("rstmid.done",   32'(bus.done), 32'd0);
    check("rstmid.result", bus.result,    32'd0);
    check("rstmid.wa",     32'(bus.wa),   32'd0);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("rstmid.dones", dones, 0);
    do_op("mul34", F3_MUL, 32'd3, 32'd4, 5'd8, 32'd12, MUL_LAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
